// File: rtl/xs3_pkg.sv
// Shared constants and state encoding for the BCD to excess-3 sequencing controller.
package xs3_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam logic [3:0]  XS3_OFFSET = 4'd3;
    localparam logic [3:0]  BCD_MAX    = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bin_to_xs3.sv
// Single-digit converter: adds the excess-3 offset to a 4-bit digit, 5-bit result.
module bin_to_xs3
    import xs3_pkg::*;
(
    input  logic [DIGIT_W-1:0] bin_i,
    output logic [DIGIT_W:0]   xs3_o
);

    assign xs3_o = {1'b0, bin_i} + {1'b0, XS3_OFFSET};

endmodule

// File: rtl/xs3_seq_ctrl.sv
// Converts a packed BCD word to excess-3 one digit per cycle through one shared converter,
// with valid/ready handshakes on both sides and a non-BCD digit error flag.
module xs3_seq_ctrl
    import xs3_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DIGIT_W*NUM_DIGITS-1:0] out_data,
    output logic                          out_err
);

    localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DataW = DIGIT_W * NUM_DIGITS;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);

    state_e              state_q;
    logic [IdxW-1:0]     idx_q;
    logic [DataW-1:0]    src_q;
    logic [DataW-1:0]    res_q;
    logic                err_q;

    logic [DIGIT_W-1:0]  cur_digit;
    logic [DIGIT_W:0]    conv_out;

    assign cur_digit = src_q[idx_q*DIGIT_W +: DIGIT_W];

    bin_to_xs3 u_conv (
        .bin_i (cur_digit),
        .xs3_o (conv_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            src_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        src_q   <= in_data;
                        res_q   <= '0;
                        err_q   <= 1'b0;
                        idx_q   <= '0;
                        state_q <= S_CONV;
                    end
                end
                S_CONV: begin
                    // Carry out (bit 4) only occurs for digits 13..15 and is dropped.
                    res_q[idx_q*DIGIT_W +: DIGIT_W] <= conv_out[DIGIT_W-1:0];
                    err_q <= err_q | (cur_digit > BCD_MAX);
                    if (idx_q == LastIdx) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_xs3_seq_ctrl.sv
// Directed bench for xs3_seq_ctrl at NUM_DIGITS = 4, 1 and 8.
module tb_xs3_seq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic        in_valid_a  [3];
    logic        out_ready_a [3];
    logic [31:0] in_data_a   [3];
    logic        in_ready_a  [3];
    logic        out_valid_a [3];
    logic        out_err_a   [3];
    logic [15:0] od0;
    logic [3:0]  od1;
    logic [31:0] od2;

    int n_checks = 0;
    int n_fail   = 0;

    xs3_seq_ctrl #(.NUM_DIGITS(4)) dut4 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_a[0]), .in_ready (in_ready_a[0]), .in_data (in_data_a[0][15:0]),
        .out_valid (out_valid_a[0]), .out_ready (out_ready_a[0]), .out_data (od0),
        .out_err (out_err_a[0])
    );

    xs3_seq_ctrl #(.NUM_DIGITS(1)) dut1 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_a[1]), .in_ready (in_ready_a[1]), .in_data (in_data_a[1][3:0]),
        .out_valid (out_valid_a[1]), .out_ready (out_ready_a[1]), .out_data (od1),
        .out_err (out_err_a[1])
    );

    xs3_seq_ctrl #(.NUM_DIGITS(8)) dut8 (
        .clk (clk), .rst_n (rst_n),
        .in_valid (in_valid_a[2]), .in_ready (in_ready_a[2]), .in_data (in_data_a[2]),
        .out_valid (out_valid_a[2]), .out_ready (out_ready_a[2]), .out_data (od2),
        .out_err (out_err_a[2])
    );

    function automatic logic [31:0] od(input int s);
        case (s)
            0:       return {16'h0, od0};
            1:       return {28'h0, od1};
            default: return od2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Full transaction with out_ready held high; checks latency, result and return to idle.
    task automatic run_word(input int s, input logic [31:0] din, input logic [31:0] exp_d,
                            input logic exp_e, input int exp_lat, input string tag);
        int lat;
        @(negedge clk);
        check({tag, ".in_ready_pre"}, 32'(in_ready_a[s]), 1);
        in_valid_a[s]  = 1'b1;
        in_data_a[s]   = din;
        out_ready_a[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[s] = 1'b0;
        lat = 0;
        while (!out_valid_a[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".data"}, od(s), exp_d);
        check({tag, ".err"}, 32'(out_err_a[s]), 32'(exp_e));
        @(negedge clk);
        check({tag, ".valid_post"}, 32'(out_valid_a[s]), 0);
        check({tag, ".in_ready_post"}, 32'(in_ready_a[s]), 1);
        out_ready_a[s] = 1'b0;
    endtask

    // in_valid and out_ready held high: accepts must be exactly N+2 cycles apart.
    task automatic back_to_back(input int s, input int n, input logic [31:0] din,
                                input logic [31:0] exp_d, input string tag);
        int t[3];
        int k;
        int w;
        k = 0;
        out_ready_a[s] = 1'b1;
        in_valid_a[s]  = 1'b1;
        in_data_a[s]   = din;
        for (int c = 0; c < 60 && k < 3; c++) begin
            @(negedge clk);
            if (in_ready_a[s]) begin
                t[k] = cyc;
                k++;
            end
        end
        check({tag, ".accepts"}, 32'(k), 3);
        if (k == 3) begin
            check({tag, ".period1"}, 32'(t[1] - t[0]), 32'(n + 2));
            check({tag, ".period2"}, 32'(t[2] - t[1]), 32'(n + 2));
        end
        @(posedge clk);
        @(negedge clk);
        in_valid_a[s] = 1'b0;
        w = 0;
        while (!in_ready_a[s] && w < 30) begin
            @(negedge clk);
            w++;
        end
        check({tag, ".idle"}, 32'(in_ready_a[s]), 1);
        check({tag, ".data"}, od(s), exp_d);
        out_ready_a[s] = 1'b0;
    endtask

    initial begin
        int w;
        for (int i = 0; i < 3; i++) begin
            in_valid_a[i]  = 1'b0;
            out_ready_a[i] = 1'b0;
            in_data_a[i]   = '0;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst.in_ready", 32'(in_ready_a[0]), 1);
        check("rst.out_valid", 32'(out_valid_a[0]), 0);
        check("rst.out_data", od(0), 0);
        check("rst.out_err", 32'(out_err_a[0]), 0);

        run_word(0, 32'h1234, 32'h4567, 1'b0, 4, "basic");
        run_word(0, 32'h0999, 32'h3CCC, 1'b0, 4, "bcd_max");
        run_word(0, 32'h0000, 32'h3333, 1'b0, 4, "zero");
        run_word(0, 32'h12A4, 32'h45D7, 1'b1, 4, "bad_a");
        run_word(0, 32'hF000, 32'h2333, 1'b1, 4, "bad_f");
        run_word(0, 32'h1234, 32'h4567, 1'b0, 4, "err_clear");

        // Backpressure: result held, second word refused while DONE.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'h4321;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        w = 0;
        while (!out_valid_a[0] && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("bp.valid", 32'(out_valid_a[0]), 1);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'h1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp.hold_valid", 32'(out_valid_a[0]), 1);
            check("bp.hold_data", od(0), 32'h7654);
            check("bp.hold_in_ready", 32'(in_ready_a[0]), 0);
        end
        in_valid_a[0]  = 1'b0;
        out_ready_a[0] = 1'b1;
        @(negedge clk);
        out_ready_a[0] = 1'b0;
        check("bp.release_valid", 32'(out_valid_a[0]), 0);
        check("bp.release_in_ready", 32'(in_ready_a[0]), 1);
        check("bp.release_data", od(0), 32'h7654);
        run_word(0, 32'h1111, 32'h4444, 1'b0, 4, "bp.second");

        // Reset asserted during the second conversion cycle.
        @(negedge clk);
        in_valid_a[0] = 1'b1;
        in_data_a[0]  = 32'h9999;
        @(posedge clk);
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        @(negedge clk);
        check("midrst.partial", od(0), 32'h000C);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.in_ready", 32'(in_ready_a[0]), 1);
        check("midrst.out_valid", 32'(out_valid_a[0]), 0);
        check("midrst.out_data", od(0), 0);
        check("midrst.out_err", 32'(out_err_a[0]), 0);
        run_word(0, 32'h5678, 32'h89AB, 1'b0, 4, "midrst.next");

        run_word(1, 32'h7, 32'hA, 1'b0, 1, "n1");
        run_word(1, 32'hB, 32'hE, 1'b1, 1, "n1_bad");
        run_word(2, 32'h98765432, 32'hCBA98765, 1'b0, 8, "n8");

        back_to_back(0, 4, 32'h2468, 32'h579B, "b2b4");
        back_to_back(1, 1, 32'h3, 32'h6, "b2b1");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected finish");
        $fatal(1);
    end

endmodule
